// File: rtl/ldseq16_pkg.sv
// ldseq16_pkg: shared FSM encoding, counter width and word-half selects for ldseq16
package ldseq16_pkg;
    typedef enum logic [1:0] {IDLE, SET, LD, ACK} state_t;
    localparam int CW = 2;
    localparam logic LO = 1'b0;
    localparam logic HI = 1'b1;
endpackage

// File: rtl/ldseq16_ldsel.sv
// ldsel: register-select to one-hot ld strobe decoder, active only in the LD state
module ldsel
    import ldseq16_pkg::*;
#(
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic [AW-1:0]   sel,
    input  state_t          state,
    output logic [NREG-1:0] ld
);
    assign ld = (state == LD) ? NREG'(1) << sel : '0;
endmodule

// File: rtl/ldseq16.sv
// ldseq16: sequences 16/32-bit writes into single-cycle ld strobes on a shared 16-bit bus
module ldseq16
    import ldseq16_pkg::*;
#(
    parameter int NREG  = 4,
    parameter int AW    = 2,
    parameter int SETUP = 1
) (
    input  logic            clk,
    input  logic            resetl,
    input  logic            wr_req,
    input  logic [AW-1:0]   wr_addr,
    input  logic            wr_long,
    input  logic [31:0]     wr_data,
    output logic            wr_ack,
    output logic            busy,
    output logic [15:0]     dout,
    output logic [NREG-1:0] ld
);
    localparam logic [CW-1:0] RELOAD = CW'(SETUP);
    localparam state_t FIRST = (SETUP == 0) ? LD : SET;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] addr, addr_n;
    logic lng, lng_n, half, half_n;
    logic [15:0] hi, hi_n, dout_n;
    logic [NREG-1:0] ld_n;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = addr;
        lng_n   = lng;
        half_n  = half;
        hi_n    = hi;
        dout_n  = dout;
        case (state)
            IDLE: if (wr_req) begin
                state_n = FIRST;
                cnt_n   = RELOAD;
                addr_n  = wr_addr;
                lng_n   = wr_long;
                half_n  = LO;
                hi_n    = wr_data[31:16];
                dout_n  = wr_data[15:0];
            end
            SET: begin
                cnt_n   = cnt - CW'(1);
                state_n = (cnt == CW'(1)) ? LD : SET;
            end
            LD: if (lng && half == LO) begin
                state_n = FIRST;
                cnt_n   = RELOAD;
                addr_n  = addr + AW'(1);
                half_n  = HI;
                dout_n  = hi;
            end else begin
                state_n = ACK;
            end
            default: state_n = IDLE;
        endcase
    end
    // strobes decode from next state so ld is a true flop output
    ldsel #(.NREG(NREG), .AW(AW)) u_ldsel (
        .sel   (addr_n),
        .state (state_n),
        .ld    (ld_n)
    );
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state  <= IDLE;
            cnt    <= '0;
            addr   <= '0;
            lng    <= 1'b0;
            half   <= LO;
            hi     <= '0;
            dout   <= '0;
            ld     <= '0;
            wr_ack <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            addr   <= addr_n;
            lng    <= lng_n;
            half   <= half_n;
            hi     <= hi_n;
            dout   <= dout_n;
            ld     <= ld_n;
            wr_ack <= (state_n == ACK);
            busy   <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_ldseq16.sv
// tb_ldseq16: directed vector table plus corner sequences and a random one-hot sweep for ldseq16
module tb_ldseq16;
    logic clk = 1'b0;
    logic resetl;
    logic wr_req, wr_long, wr_ack, busy;
    logic [1:0] wr_addr;
    logic [31:0] wr_data;
    logic [15:0] dout;
    logic [3:0] ld;
    logic s0_req, s0_long, s0_ack, s0_busy;
    logic [1:0] s0_addr;
    logic [31:0] s0_data;
    logic [15:0] s0_dout;
    logic [3:0] s0_ld;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]  addr;
        logic        lng;
        logic [31:0] data;
        logic [3:0]  ld_a;
        logic [15:0] do_a;
        logic [3:0]  ld_b;
        logic [15:0] do_b;
    } vec_t;
    vec_t vecs[5];

    ldseq16 #(.NREG(4), .AW(2), .SETUP(1)) dut (
        .clk(clk), .resetl(resetl), .wr_req(wr_req), .wr_addr(wr_addr), .wr_long(wr_long),
        .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy), .dout(dout), .ld(ld)
    );
    ldseq16 #(.NREG(4), .AW(2), .SETUP(0)) dut0 (
        .clk(clk), .resetl(resetl), .wr_req(s0_req), .wr_addr(s0_addr), .wr_long(s0_long),
        .wr_data(s0_data), .wr_ack(s0_ack), .busy(s0_busy), .dout(s0_dout), .ld(s0_ld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        wr_addr = v.addr;
        wr_long = v.lng;
        wr_data = v.data;
        wr_req  = 1'b1;
        tick();
        wr_req  = 1'b0;
        wr_data = ~v.data;
        wr_addr = v.addr + 2'd1;
        chk("c1_busy", busy, 1);
        chk("c1_ld", ld, 0);
        chk("c1_dout", dout, v.do_a);
        tick();
        chk("ld_a", ld, v.ld_a);
        chk("dout_a", dout, v.do_a);
        chk("ack_early", wr_ack, 0);
        if (v.lng) begin
            tick();
            chk("gap_ld", ld, 0);
            chk("dout_b", dout, v.do_b);
            tick();
            chk("ld_b", ld, v.ld_b);
            chk("dout_b_ld", dout, v.do_b);
        end
        tick();
        chk("ack", wr_ack, 1);
        chk("ack_ld", ld, 0);
        chk("ack_busy", busy, 1);
        tick();
        chk("idle_ack", wr_ack, 0);
        chk("idle_busy", busy, 0);
        chk("hold_dout", dout, v.lng ? v.do_b : v.do_a);
    endtask

    initial begin
        int issued, exp_lds, lds, acks, bad, stray;
        vecs[0] = '{2'd2, 1'b0, 32'h0000_1234, 4'b0100, 16'h1234, 4'b0000, 16'h0000};
        vecs[1] = '{2'd3, 1'b1, 32'hBEEF_CAFE, 4'b1000, 16'hCAFE, 4'b0001, 16'hBEEF};
        vecs[2] = '{2'd0, 1'b0, 32'hFFFF_0001, 4'b0001, 16'h0001, 4'b0000, 16'h0000};
        vecs[3] = '{2'd1, 1'b1, 32'h1234_5678, 4'b0010, 16'h5678, 4'b0100, 16'h1234};
        vecs[4] = '{2'd2, 1'b1, 32'hA5A5_0F0F, 4'b0100, 16'h0F0F, 4'b1000, 16'hA5A5};
        resetl = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_long = 1'b0; wr_data = '0;
        s0_req = 1'b0; s0_addr = '0; s0_long = 1'b0; s0_data = '0;
        tick();
        tick();
        chk("rst_ld", ld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", wr_ack, 0);
        chk("rst_dout", dout, 0);
        chk("rst0_ld", s0_ld, 0);
        chk("rst0_busy", s0_busy, 0);
        resetl = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // SETUP=0 long write: loads on consecutive cycles
        s0_addr = 2'd0; s0_long = 1'b1; s0_data = 32'h5555_AAAA; s0_req = 1'b1;
        tick();
        s0_req = 1'b0;
        chk("s0_ld1", s0_ld, 4'b0001);
        chk("s0_dout1", s0_dout, 16'hAAAA);
        chk("s0_busy1", s0_busy, 1);
        tick();
        chk("s0_ld2", s0_ld, 4'b0010);
        chk("s0_dout2", s0_dout, 16'h5555);
        tick();
        chk("s0_ack", s0_ack, 1);
        chk("s0_ack_ld", s0_ld, 0);
        tick();
        chk("s0_idle", s0_busy, 0);

        // request while busy ignored, then accepted as busy falls
        wr_addr = 2'd2; wr_long = 1'b0; wr_data = 32'h0000_1111; wr_req = 1'b1;
        tick();
        wr_addr = 2'd1; wr_data = 32'h0000_2222;
        tick();
        chk("busy_ld_first", ld, 4'b0100);
        chk("busy_dout_first", dout, 16'h1111);
        tick();
        chk("busy_ack", wr_ack, 1);
        tick();
        chk("busy_fall", busy, 0);
        tick();
        wr_req = 1'b0;
        chk("reaccept_busy", busy, 1);
        chk("reaccept_dout", dout, 16'h2222);
        tick();
        chk("reaccept_ld", ld, 4'b0010);
        tick();
        chk("reaccept_ack", wr_ack, 1);
        tick();

        // reset during SET of the second word of a long write
        wr_addr = 2'd3; wr_long = 1'b1; wr_data = 32'hBEEF_CAFE; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        tick();
        chk("mid_ld_first", ld, 4'b1000);
        tick();
        chk("mid_dout_hi", dout, 16'hBEEF);
        #2;
        resetl = 1'b0;
        #1;
        chk("mid_rst_ld", ld, 0);
        chk("mid_rst_ack", wr_ack, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_dout", dout, 0);
        @(negedge clk);
        resetl = 1'b1;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ld != 0 || wr_ack) stray++;
        end
        chk("mid_no_ld_after", stray, 0);

        // random traffic
        issued = 0; exp_lds = 0; lds = 0; acks = 0; bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if ($countones(ld) > 1) bad++;
            if (ld != 0) lds++;
            if (wr_ack) acks++;
            if (!busy && $urandom_range(0, 1) == 1) begin
                wr_addr = 2'($urandom_range(0, 3));
                wr_long = 1'($urandom_range(0, 1));
                wr_data = $urandom;
                wr_req  = 1'b1;
                issued++;
                exp_lds += wr_long ? 2 : 1;
            end else begin
                wr_req = 1'b0;
            end
            tick();
        end
        wr_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if ($countones(ld) > 1) bad++;
            if (ld != 0) lds++;
            if (wr_ack) acks++;
            tick();
        end
        chk("rnd_onehot", bad, 0);
        chk("rnd_acks", acks, issued);
        chk("rnd_lds", lds, exp_lds);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ldseq16.md
Name: ldseq16

Overview:
- Write-side sequencer feeding banks of 16-bit load-enable holding registers (fd1e-based, loaded by a per-register `ld` strobe on the shared `clk`).
- Accepts a CPU/GPU-style write request (16- or 32-bit) and presents the data word on a shared 16-bit bus.
- Fires exactly one single-cycle `ld` strobe per target register, splitting 32-bit writes into two 16-bit loads.
- Returns an acknowledge to the requester.

Parameters:
- NREG, 4, number of downstream 16-bit registers (ld strobes); power of two, 2..16.
- AW, 2, register-select width; equals log2(NREG).
- SETUP, 1, cycles `dout` is held stable before each `ld` pulse (0..3).

Ports:
- clk  in  1  system clock
- resetl  in  1  asynchronous active-low reset
- wr_req  in  1  write request; sampled only in IDLE
- wr_addr  in  AW  target register index (low word for long writes)
- wr_long  in  1  1 = 32-bit write (two registers), 0 = 16-bit write
- wr_data  in  32  write data; bits 0..15 low word, bits 16..31 high word
- wr_ack  out  1  one-cycle pulse when the last load of the request has fired
- busy  out  1  high from acceptance until the cycle after wr_ack
- dout  out  16  data bus to all downstream register `ti` inputs
- ld  out  NREG  one-hot load strobes, at most one bit set per cycle

Behaviour:
- Reset (async, resetl=0):
  - State IDLE; dout=0, ld=0, wr_ack=0, busy=0.
  - Internal address, data and counter registers cleared.
  - Applies mid-operation too: a pending write is abandoned with no ld and no wr_ack.
- Release: first active edge after resetl rises may accept a request.
- All outputs are registered (no combinational path from inputs to outputs).
- States:
  - IDLE: if wr_req=1 at an edge, capture wr_addr/wr_long/wr_data; busy=1; dout=wr_data[0:15]; counter=SETUP. Go to SET, or to LD when SETUP=0.
  - SET: count down and hold dout. When counter reaches 0, go to LD.
  - LD: ld[addr]=1 for exactly one cycle; dout unchanged.
    - If long and first word: next cycle dout=wr_data[16:31], addr=addr+1 modulo NREG (wrap from NREG-1 to 0), counter reloaded, go to SET (or LD when SETUP=0).
    - Otherwise go to ACK.
  - ACK: wr_ack=1 for one cycle, busy=1; ld=0; dout held. Next state IDLE with busy=0.
- Latency from wr_req edge to ld pulse, in cycles:
  - Short write: ld asserts SETUP+1 cycles after acceptance.
  - wr_ack follows ld by one cycle.
  - Long write: second ld asserts SETUP+1 cycles after the first; wr_ack one cycle after the second ld.
- wr_req while busy is ignored (not queued). The requester must hold off until busy=0.
- wr_req asserted in the same cycle busy falls is accepted; back-to-back throughput is one request per (loads×(SETUP+1)+2) cycles.
- dout keeps its last value in IDLE; it is never forced to 0 except by reset.
- ld is never asserted in IDLE, SET or ACK. Never two bits at once.
- wr_data/wr_addr changes after acceptance have no effect.

Decomposition:
- Shared package: state encoding (IDLE, SET, LD, ACK), SETUP counter width constant (2 bits), word-half select constants (LO=0, HI=1).
- One natural sub-module, `ldsel`: AW-to-NREG one-hot decoder gated by the LD state.
- FSM, counter and data/address capture stay in ldseq16.

Test Plan:
- Reset mid-long-write: NREG=4, SETUP=1; resetl=0 during SET of the second word -> ld=0, wr_ack=0, busy=0, dout=0 immediately; no further ld after release.
- Short write, SETUP=1: wr_addr=2, wr_data=0x0000_1234, wr_long=0 -> dout=0x1234 from cycle 1; ld=4'b0100 at cycle 2 only; wr_ack at cycle 3; busy 1 in cycles 1..3.
- Long write with wrap: wr_addr=3, wr_data=0xBEEF_CAFE, wr_long=1, SETUP=1 -> ld[3] with dout=0xCAFE at cycle 2; ld[0] with dout=0xBEEF at cycle 4; wr_ack at cycle 5.
- SETUP=0 long write: wr_addr=0, data 0x5555_AAAA -> ld[0] at cycle 1 (0xAAAA), ld[1] at cycle 2 (0x5555), wr_ack at cycle 3.
- Request while busy: second wr_req (addr 1) during SET of the first -> ignored; only the first ld fires. A new wr_req held through the busy-fall cycle is accepted then.
- One-hot check: random requests over 1000 cycles -> popcount(ld)≤1 every cycle; exactly one wr_ack per accepted request; ld count = 1 or 2 per request according to wr_long.
